spi_slave_fifo: RTL and testbench
=================================

// Module: spi_slave_fifo
// PURPOSE
//  SPI slave with runtime CPOL/CPHA, parametrised word width, and TX/RX FIFOs.
//  Supports continuous multi-word frames while ss_n stays low.
//  Sits between external SPI pins (oversampled on clk) and on-chip logic.
//  Both sides of the block use valid/ready streams.
// PARAMETERS
//  WIDTH       8  bits per SPI word (>=2)
//  DEPTH       4  entries per FIFO (power of two, >=2)
//  LSB_FIRST   0  0: MSB shifted first, 1: LSB shifted first
//  SYNC_STAGES 2  synchroniser flops on sclk/ss_n/mosi (>=2)
// PORTS
//  clk        in   1      system clock; must run >= 4x sclk frequency
//  reset      in   1      asynchronous, active-low
//  mode       in   2      {CPOL,CPHA}; latched on synced ss_n falling edge
//  sclk       in   1      SPI clock pin (asynchronous)
//  ss_n       in   1      SPI select pin, active-low (asynchronous)
//  mosi       in   1      SPI data in (asynchronous)
//  miso       out  1      SPI data out
//  miso_oe    out  1      miso drive enable; equals synced ~ss_n
//  tx_data    in   WIDTH  word to transmit
//  tx_valid   in   1      tx_data valid
//  tx_ready   out  1      TX FIFO not full
//  rx_data    out  WIDTH  received word, first-word-fall-through
//  rx_valid   out  1      RX FIFO not empty
//  rx_ready   in   1      consumer pops rx_data
//  tx_level   out  $clog2(DEPTH+1)  TX FIFO occupancy
//  rx_level   out  $clog2(DEPTH+1)  RX FIFO occupancy
//  tx_underrun out 1      sticky: word slot started with TX FIFO empty
//  rx_overrun  out 1      sticky: word received with RX FIFO full, word dropped
//  frame_err  out  1      1-cycle pulse: ss_n rose with bit count != 0
//  clr_flags  in   1      clears tx_underrun and rx_overrun
// BEHAVIOUR
//  Reset: all outputs 0 except tx_ready=1. FIFOs empty, bit counter 0, mode=00.
//   Sticky flags cleared.
//  Pins pass through SYNC_STAGES flops; sclk edges come from synced sclk vs its delayed copy.
//  Leading edge: rising if CPOL=0, falling if CPOL=1. Trailing edge is the opposite.
//  CPHA=0: sample on leading edge, shift on trailing edge.
//  CPHA=1: shift on leading edge, sample on trailing edge.
//  Word start (ss_n fall, or the sample of the last bit while ss_n stays low):
//   - pop the TX FIFO into the shift register;
//   - if the FIFO is empty, load all zeros and set tx_underrun;
//   - if CPHA=0, miso drives the first bit in the same cycle as the load.
//  For CPHA=1 the first bit is driven on the first leading edge.
//  Bit counter runs 0..WIDTH-1 and wraps to 0 after the last sample.
//  On wrap, the received word is pushed to the RX FIFO.
//   - If the RX FIFO is full and rx_ready=0, the word is dropped and rx_overrun is set.
//   - rx_valid rises on the clk cycle after the push.
//  FIFO same-cycle rules:
//   - Full RX FIFO with rx_ready=1 and a push: both happen, level unchanged.
//   - TX FIFO: tx_valid&&tx_ready pushes. A same-cycle pop from an empty FIFO is an
//     underrun (no bypass).
//  ss_n rising (synced):
//   - partial word discarded, nothing pushed;
//   - counter reset; frame_err pulses if counter != 0;
//   - a TX word already popped is lost (not re-queued).
//  sclk edges while ss_n high are ignored. mode changes while ss_n is low are ignored.
//  clr_flags and a new set event in the same cycle: the set wins.
//  Asynchronous reset mid-transfer aborts at once. FIFO contents are lost.
//  Latency: pin sample edge -> internal capture = SYNC_STAGES+1 clk cycles.
// TESTING
//  1 Mode 00, WIDTH=8: TX FIFO holds A5; master sends 3C -> miso A5 MSB first,
//    rx_data=3C, rx_valid=1.
//  2 Modes 01/10/11, ss_n held low for 3 words (11,22,33 each way) -> all words
//    exchanged, no errors, levels return to 0.
//  3 TX FIFO empty at ss_n fall -> miso 00 for the whole word, tx_underrun=1;
//    clr_flags clears it.
//  4 RX FIFO filled to DEPTH=4 and rx_ready=0, 5th word 77 -> 77 dropped,
//    rx_overrun=1, rx_level=4.
//  5 ss_n rises after 5 bits -> frame_err 1-cycle pulse, rx_level unchanged;
//    next frame receives correctly.
//  6 reset low during bit 3 -> all outputs at reset values, tx_ready=1; next
//    transfer is clean.

Source files
------------

// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: oversampled SPI slave (runtime CPOL/CPHA) with TX/RX FWFT FIFOs.
// Rev 1.0
`default_nettype none

module spi_slave_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]    r_count;
  logic             w_do_push, w_do_pop;

  assign full      = (r_count == LW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_pop  = pop && !empty;
  // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
  assign w_do_push = push && (!full || w_do_pop);
  assign head      = empty ? '0 : r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module spi_slave_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter bit LSB_FIRST   = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 mode,
  input  logic                       sclk,
  input  logic                       ss_n,
  input  logic                       mosi,
  output logic                       miso,
  output logic                       miso_oe,
  input  logic [WIDTH-1:0]           tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [WIDTH-1:0]           rx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [$clog2(DEPTH+1)-1:0] tx_level,
  output logic [$clog2(DEPTH+1)-1:0] rx_level,
  output logic                       tx_underrun,
  output logic                       rx_overrun,
  output logic                       frame_err,
  input  logic                       clr_flags
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
  logic                   r_sclk_d, r_ss_d;
  logic [1:0]             r_mode;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_tx_sr, r_rx_sr;
  logic                   r_miso, r_frame_err, r_underrun, r_overrun;

  logic w_sclk, w_ss, w_mosi, w_ss_fall, w_ss_rise, w_active;
  logic w_rise, w_fall, w_lead, w_trail, w_sample, w_shift, w_last;
  logic w_word_start, w_start_cpha, w_underrun_set, w_overrun_set;
  logic w_tx_push, w_tx_full, w_tx_empty, w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [WIDTH-1:0] w_tx_head, w_tx_word, w_rx_word;

  function automatic logic out_bit(input logic [WIDTH-1:0] x);
    return LSB_FIRST ? x[0] : x[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] x);
    return LSB_FIRST ? (x >> 1) : (x << 1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss      = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss_fall = !w_ss && r_ss_d;
  assign w_ss_rise = w_ss && !r_ss_d;
  assign w_active  = !w_ss && !r_ss_d;
  assign w_rise    = w_sclk && !r_sclk_d;
  assign w_fall    = !w_sclk && r_sclk_d;
  assign w_lead    = w_active && (r_mode[1] ? w_fall : w_rise);
  assign w_trail   = w_active && (r_mode[1] ? w_rise : w_fall);
  assign w_sample  = r_mode[0] ? w_trail : w_lead;
  // With CPHA=0 the trailing edge after the last sample must not disturb the freshly loaded word.
  assign w_shift   = r_mode[0] ? w_lead : (w_trail && (r_cnt != '0));
  assign w_last    = w_sample && (r_cnt == CW'(WIDTH-1));

  assign w_word_start = w_ss_fall || w_last;
  assign w_start_cpha = w_ss_fall ? mode[0] : r_mode[0];
  assign w_tx_word    = w_tx_empty ? '0 : w_tx_head;
  assign w_rx_word    = LSB_FIRST ? {w_mosi, r_rx_sr[WIDTH-1:1]} : {r_rx_sr[WIDTH-2:0], w_mosi};

  assign w_tx_push      = tx_valid && !w_tx_full;
  assign w_rx_pop       = rx_ready && !w_rx_empty;
  assign w_rx_push      = w_last && (!w_rx_full || rx_ready);
  assign w_underrun_set = w_word_start && w_tx_empty;
  assign w_overrun_set  = w_last && w_rx_full && !rx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode      <= 2'b00;
      r_cnt       <= '0;
      r_tx_sr     <= '0;
      r_rx_sr     <= '0;
      r_miso      <= 1'b0;
      r_frame_err <= 1'b0;
      r_underrun  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ss_rise && (r_cnt != '0);
      if (w_ss_fall) r_mode <= mode;
      if (w_ss_rise) begin
        r_cnt  <= '0;
        r_miso <= 1'b0;
      end else begin
        if (w_sample) begin
          r_rx_sr <= w_rx_word;
          r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
        end
        if (w_word_start) begin
          if (!w_start_cpha) begin
            r_miso  <= out_bit(w_tx_word);
            r_tx_sr <= shift_out(w_tx_word);
          end else begin
            r_tx_sr <= w_tx_word;
          end
        end else if (w_shift) begin
          r_miso  <= out_bit(r_tx_sr);
          r_tx_sr <= shift_out(r_tx_sr);
        end
      end
      // A set event in the same cycle as clr_flags takes priority.
      if (w_underrun_set)  r_underrun <= 1'b1;
      else if (clr_flags)  r_underrun <= 1'b0;
      if (w_overrun_set)   r_overrun  <= 1'b1;
      else if (clr_flags)  r_overrun  <= 1'b0;
    end
  end

  spi_slave_fifo_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_tx_push),
    .push_data (tx_data),
    .pop       (w_word_start),
    .head      (w_tx_head),
    .count     (tx_level),
    .full      (w_tx_full),
    .empty     (w_tx_empty)
  );

  spi_slave_fifo_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_rx_push),
    .push_data (w_rx_word),
    .pop       (w_rx_pop),
    .head      (rx_data),
    .count     (rx_level),
    .full      (w_rx_full),
    .empty     (w_rx_empty)
  );

  assign miso        = r_miso;
  assign miso_oe     = !w_ss;
  assign tx_ready    = !w_tx_full;
  assign rx_valid    = !w_rx_empty;
  assign tx_underrun = r_underrun;
  assign rx_overrun  = r_overrun;
  assign frame_err   = r_frame_err;
endmodule

`default_nettype wire

// File: tb/tb_spi_slave_fifo.sv
// tb_spi_slave_fifo: directed SPI master stimulus with hand-computed expected words.
// Rev 1.0
`default_nettype none

module tb_spi_slave_fifo;
  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready = 1'b0;
  logic [2:0] tx_level, rx_level;
  logic       tx_underrun, rx_overrun, frame_err;
  logic       clr_flags = 1'b0;

  int n_total = 0;
  int n_bad   = 0;
  int fe_cnt  = 0;
  logic cpol = 1'b0, cpha = 1'b0;

  spi_slave_fifo #(.WIDTH(8), .DEPTH(4), .LSB_FIRST(1'b0), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_level(tx_level), .rx_level(rx_level), .tx_underrun(tx_underrun),
    .rx_overrun(rx_overrun), .frame_err(frame_err), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pop_rx(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check({tag, "_valid"}, 32'(rx_valid), 32'd1);
    check({tag, "_data"}, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic clear_flags();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  task automatic frame_begin(input logic [1:0] m);
    mode = m;
    cpol = m[1];
    cpha = m[0];
    @(negedge clk);
    sclk = cpol;
    wait_clk(6);
    ss_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic frame_end();
    wait_clk(8);
    ss_n = 1'b1;
    wait_clk(8);
  endtask

  // Master shifts MSB first; all pin changes fall on clk negedges.
  task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (!cpha) begin
        mosi = mo[7-i];
        #HALF;
        sclk = ~cpol;
        mi = {mi[6:0], miso};
        #HALF;
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo[7-i];
        #HALF;
        sclk = cpol;
        mi = {mi[6:0], miso};
        #HALF;
      end
    end
  endtask

  logic [7:0] got;
  logic [7:0] words [3];
  int fe0;

  initial begin
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    wait_clk(3);
    reset = 1'b1;
    wait_clk(2);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_levels", {tx_level, rx_level}, 32'd0);
    check("rst_flags", {tx_underrun, rx_overrun, frame_err}, 32'd0);
    check("rst_pins", {miso, miso_oe}, 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);

    // 1: mode 00 single word
    push_tx(8'hA5);
    check("t1_tx_level", 32'(tx_level), 32'd1);
    frame_begin(2'b00);
    check("t1_miso_oe", 32'(miso_oe), 32'd1);
    spi_bits(8'h3C, 8, got);
    check("t1_miso_word", 32'(got), 32'hA5);
    wait_clk(6);
    check("t1_rx_level", 32'(rx_level), 32'd1);
    pop_rx("t1_rx", 8'h3C);
    frame_end();
    check("t1_miso_oe_off", 32'(miso_oe), 32'd0);
    clear_flags();

    // 2: multi-word frames in the other three modes
    for (int m = 1; m < 4; m++) begin
      fe0 = fe_cnt;
      for (int w = 0; w < 3; w++) push_tx(words[w]);
      frame_begin(2'(m));
      for (int w = 0; w < 3; w++) begin
        spi_bits(words[w], 8, got);
        check($sformatf("t2_m%0d_miso%0d", m, w), 32'(got), 32'(words[w]));
      end
      frame_end();
      check($sformatf("t2_m%0d_tx_level", m), 32'(tx_level), 32'd0);
      check($sformatf("t2_m%0d_rx_level", m), 32'(rx_level), 32'd3);
      check($sformatf("t2_m%0d_errs", m), {31'(fe_cnt - fe0), rx_overrun}, 32'd0);
      for (int w = 0; w < 3; w++) pop_rx($sformatf("t2_m%0d_rx%0d", m, w), words[w]);
      check($sformatf("t2_m%0d_rx_empty", m), 32'(rx_level), 32'd0);
      clear_flags();
    end

    // 3: TX underrun
    frame_begin(2'b00);
    check("t3_underrun_set", 32'(tx_underrun), 32'd1);
    spi_bits(8'h5A, 8, got);
    check("t3_miso_zero", 32'(got), 32'h00);
    frame_end();
    pop_rx("t3_rx", 8'h5A);
    clear_flags();
    check("t3_underrun_clr", 32'(tx_underrun), 32'd0);

    // 4: RX overrun with rx_ready held low
    frame_begin(2'b00);
    for (int w = 1; w <= 4; w++) spi_bits(8'(w), 8, got);
    wait_clk(6);
    check("t4_rx_full", 32'(rx_level), 32'd4);
    check("t4_no_overrun", 32'(rx_overrun), 32'd0);
    spi_bits(8'h77, 8, got);
    frame_end();
    check("t4_overrun", 32'(rx_overrun), 32'd1);
    check("t4_rx_level", 32'(rx_level), 32'd4);
    for (int w = 1; w <= 4; w++) pop_rx($sformatf("t4_rx%0d", w), 8'(w));
    check("t4_rx_empty", 32'(rx_valid), 32'd0);
    clear_flags();
    check("t4_overrun_clr", 32'(rx_overrun), 32'd0);

    // 5: frame aborted after 5 bits
    fe0 = fe_cnt;
    frame_begin(2'b00);
    spi_bits(8'hF0, 5, got);
    frame_end();
    check("t5_frame_err_pulse", 32'(fe_cnt - fe0), 32'd1);
    check("t5_rx_level", 32'(rx_level), 32'd0);
    clear_flags();
    push_tx(8'hC3);
    frame_begin(2'b00);
    spi_bits(8'h96, 8, got);
    check("t5_next_miso", 32'(got), 32'hC3);
    frame_end();
    pop_rx("t5_next_rx", 8'h96);
    clear_flags();

    // 6: reset mid-transfer
    push_tx(8'h5A);
    push_tx(8'h44);
    frame_begin(2'b00);
    spi_bits(8'hAA, 3, got);
    @(negedge clk);
    reset = 1'b0;
    wait_clk(2);
    check("t6_rst_tx_ready", 32'(tx_ready), 32'd1);
    check("t6_rst_levels", {tx_level, rx_level}, 32'd0);
    check("t6_rst_outs", {miso, miso_oe, rx_valid, tx_underrun, rx_overrun, frame_err}, 32'd0);
    ss_n = 1'b1;
    wait_clk(2);
    reset = 1'b1;
    wait_clk(4);
    push_tx(8'h81);
    frame_begin(2'b00);
    spi_bits(8'h18, 8, got);
    check("t6_clean_miso", 32'(got), 32'h81);
    frame_end();
    pop_rx("t6_clean_rx", 8'h18);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
